// File: rtl/log2_scan_engine.sv
// log2_scan_engine: handshaked floor/ceil/exact log2 of an unsigned operand.
// The operand is scanned CHUNK bits per cycle from the MSB down, and the scan
// stops at the first nonzero chunk. A zero operand scans every chunk.
module log2_scan_engine #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_log,
  output logic             out_zero,
  output logic             out_pow2,
  output logic             out_err
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] M_FLOOR = 2'b00;
  localparam logic [1:0] M_CEIL  = 2'b01;
  localparam logic [1:0] M_EXACT = 2'b10;
  localparam logic [1:0] M_RSVD  = 2'b11;

  logic [1:0]       state;
  logic [WIDTH-1:0] opnd;
  logic [1:0]       mode;
  logic [IDX_W-1:0] idx;
  logic             pow2;

  logic [WIDTH-1:0] shifted;
  logic [CHUNK-1:0] chunk;
  logic             chunk_nz;
  logic [OUT_W-1:0] msb;
  logic [OUT_W-1:0] log_res;
  logic             err_res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Current chunk, highest set bit within it, and the mode-dependent result.
  always_comb begin
    int hi;
    shifted  = opnd >> (int'(idx) * CHUNK);
    chunk    = shifted[CHUNK-1:0];
    chunk_nz = |chunk;
    hi       = 0;
    for (int i = 0; i < CHUNK; i++)
      if (chunk[i]) hi = i;
    msb      = OUT_W'(int'(idx) * CHUNK + hi);
    log_res  = (mode == M_CEIL && !pow2) ? msb + OUT_W'(1) : msb;
    err_res  = (mode == M_RSVD) || (mode == M_EXACT && !pow2);
  end

  // Handshake FSM, operand capture, chunk walk and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      opnd     <= '0;
      mode     <= M_FLOOR;
      idx      <= '0;
      pow2     <= 1'b0;
      out_log  <= '0;
      out_zero <= 1'b0;
      out_pow2 <= 1'b0;
      out_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          opnd  <= in_data;
          mode  <= in_mode;
          idx   <= IDX_W'(NCHUNK - 1);
          pow2  <= (in_data != '0) && ((in_data & (in_data - WIDTH'(1))) == '0);
          state <= SCAN;
        end
        SCAN: begin
          if (chunk_nz) begin
            out_log  <= log_res;
            out_zero <= 1'b0;
            out_pow2 <= pow2;
            out_err  <= err_res;
            state    <= DONE;
          end else if (idx != '0) begin
            idx <= idx - IDX_W'(1);
          end else begin
            // Every chunk was zero: the operand is zero, an error in any mode.
            out_log  <= '0;
            out_zero <= 1'b1;
            out_pow2 <= 1'b0;
            out_err  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
